// File: rtl/fetch_unit_if.sv
// Bus bundle for fetch_unit: instruction-memory req/ack port, redirect input and decode valid/ready port.
// The master modport is the fetch unit; the slave modport is the memory/decode side.
interface fetch_unit_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i;

   modport master (
      output imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
      input  imem_ack_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, instr_pc_o,
      output imem_ack_i, imem_rdata_i, redirect_i, redirect_pc_i, instr_ready_i
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack into a DEPTH-entry prefetch FIFO, redirect with drain.
// Optional macro FETCH_STATS_EN adds fetch_cnt_o, a wrapping count of FIFO pushes.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
`ifdef FETCH_STATS_EN
   output logic [31:0] fetch_cnt_o,
`endif
   fetch_unit_if.master bus
);
   localparam int unsigned PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

   typedef enum logic {RUN, DRAIN} state_t;

   state_t        state, state_next;
   logic [31:0]   fetch_pc, fetch_pc_next;
   logic [31:0]   pending_pc, pending_pc_next;
   logic [31:0]   drop_addr, drop_addr_next;
   logic [PW:0]   count;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   fifo_instr [DEPTH];
   logic [31:0]   fifo_pc [DEPTH];
   logic          req, ack, push, pop, flush, valid;
   logic [31:0]   target;

   assign target = bus.redirect_pc_i & ~32'h3;
   assign req    = !rst && ((state == DRAIN) || (count < FULL));
   assign ack    = req && bus.imem_ack_i;
   assign valid  = (count != '0);
   assign pop    = valid && bus.instr_ready_i;

   assign bus.imem_req_o    = req;
   assign bus.imem_addr_o   = (state == DRAIN) ? drop_addr : fetch_pc;
   assign bus.instr_valid_o = valid;
   assign bus.instr_o       = valid ? fifo_instr[rd_ptr] : '0;
   assign bus.instr_pc_o    = valid ? fifo_pc[rd_ptr] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         fetch_pc   <= RESET_PC;
         pending_pc <= RESET_PC;
         drop_addr  <= RESET_PC;
      end else begin
         state      <= state_next;
         fetch_pc   <= fetch_pc_next;
         pending_pc <= pending_pc_next;
         drop_addr  <= drop_addr_next;
      end
   end

   // A redirect with a request in flight must still see that request acked before the new PC is fetched.
   always_comb begin
      state_next      = state;
      fetch_pc_next   = fetch_pc;
      pending_pc_next = pending_pc;
      drop_addr_next  = drop_addr;
      push            = 1'b0;
      flush           = 1'b0;
      case (state)
         RUN: begin
            if (bus.redirect_i) begin
               flush           = 1'b1;
               pending_pc_next = target;
               if (ack) begin
                  fetch_pc_next = target;
               end else if (req) begin
                  drop_addr_next = fetch_pc;
                  state_next     = DRAIN;
               end else begin
                  fetch_pc_next = target;
               end
            end else if (ack) begin
               push          = 1'b1;
               fetch_pc_next = fetch_pc + 32'd4;
            end
         end
         DRAIN: begin
            if (bus.redirect_i) begin
               pending_pc_next = target;
            end
            if (ack) begin
               fetch_pc_next = bus.redirect_i ? target : pending_pc;
               state_next    = RUN;
            end
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; the output mux hides stale entries while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wr_ptr] <= bus.imem_rdata_i;
         fifo_pc[wr_ptr]    <= fetch_pc;
      end
   end

`ifdef FETCH_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_o <= '0;
      end else if (push) begin
         fetch_cnt_o <= fetch_cnt_o + 32'd1;
      end
   end
`endif
endmodule
